// File: rtl/spi_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_src_arbiter
// Brief    : Priority selector forwarding one of NUM_SRC SPI masters to one
//            slave port; switches only between frames, with an idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module spi_src_arbiter #(
    parameter int          NUM_SRC     = 4,
    parameter int          SEL_W       = 2,
    parameter int          DEFAULT_SRC = 0,
    parameter logic [15:0] HOLD_MS     = 16'd100,
    parameter int          GAP_CYC     = 8,
    parameter logic        CPOL        = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLK_1kHz,
    input  logic [NUM_SRC-1:0] REQ,
    input  logic [NUM_SRC-1:0] CS_IN,
    input  logic [NUM_SRC-1:0] SCK_IN,
    input  logic [NUM_SRC-1:0] MOSI_IN,
    output logic               CS_OUT,
    output logic               CLK_OUT,
    output logic               MOSI_OUT,
    output logic [SEL_W-1:0]   ACT_SRC,
    output logic               BLANK,
    output logic               SWITCH_P
);

    localparam int                 c_GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);
    localparam logic [SEL_W-1:0]   c_DEF_SRC  = SEL_W'(DEFAULT_SRC);

    typedef enum logic [0:0] {
        S_CONNECT = 1'b0,
        S_BLANK   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_act;
    logic [SEL_W-1:0]   w_act_nxt;
    logic [SEL_W-1:0]   w_winner;
    logic               r_k1;
    logic               r_k2;
    logic               w_tick;
    logic [15:0]        r_hold_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               w_req_act;
    logic               w_hold_exp;
    logic               w_want;
    logic               w_gap_last;
    logic               r_cs;
    logic               r_sck;
    logic               r_mosi;
    logic               r_switch_p;

    assign w_tick     = r_k1 & ~r_k2;
    assign w_req_act  = REQ[r_act];
    assign w_gap_last = (r_gap_cnt == c_GAP_LAST);
    assign w_hold_exp = (r_hold_cnt >= HOLD_MS) || (!w_req_act && (HOLD_MS == 16'd0));

    // Lowest requesting index wins; the default source is picked when nobody asks.
    always_comb begin
        w_winner = c_DEF_SRC;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                w_winner = SEL_W'(i);
            end
        end
    end

    assign w_want = (w_winner != r_act) &&
                    ((REQ[w_winner] && (w_winner < r_act)) || w_hold_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_act;
        case (r_state)
            S_CONNECT: begin
                if (w_want && CS_IN[r_act]) begin
                    w_state_nxt = S_BLANK;
                end
            end
            S_BLANK: begin
                if (w_gap_last) begin
                    w_state_nxt = S_CONNECT;
                    w_act_nxt   = w_winner;
                end
            end
            default: w_state_nxt = S_CONNECT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_CONNECT;
            r_act   <= c_DEF_SRC;
        end else begin
            r_state <= w_state_nxt;
            r_act   <= w_act_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_k1       <= 1'b0;
            r_k2       <= 1'b0;
            r_gap_cnt  <= '0;
            r_hold_cnt <= '0;
            r_cs       <= 1'b1;
            r_sck      <= CPOL;
            r_mosi     <= 1'b0;
            r_switch_p <= 1'b0;
        end else begin
            r_k1       <= CLK_1kHz;
            r_k2       <= r_k1;
            r_switch_p <= (r_state == S_BLANK) && w_gap_last && (w_winner != r_act);

            if ((r_state == S_BLANK) && !w_gap_last) begin
                r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end

            // A request on the active source beats a coincident tick.
            if (((r_state == S_BLANK) && w_gap_last) || w_req_act) begin
                r_hold_cnt <= '0;
            end else if (w_tick && (r_hold_cnt < HOLD_MS)) begin
                r_hold_cnt <= r_hold_cnt + 16'd1;
            end

            // Idle levels are loaded on the edge entering the gap so the slave
            // sees BLANK and an idle bus in the same cycle.
            if (w_state_nxt == S_BLANK) begin
                r_cs   <= 1'b1;
                r_sck  <= CPOL;
                r_mosi <= 1'b0;
            end else begin
                r_cs   <= CS_IN[w_act_nxt];
                r_sck  <= SCK_IN[w_act_nxt];
                r_mosi <= MOSI_IN[w_act_nxt];
            end
        end
    end

    assign CS_OUT   = r_cs;
    assign CLK_OUT  = r_sck;
    assign MOSI_OUT = r_mosi;
    assign ACT_SRC  = r_act;
    assign BLANK    = (r_state == S_BLANK);
    assign SWITCH_P = r_switch_p;

endmodule
`default_nettype wire

// File: doc/spi_src_arbiter.md
Name: spi_src_arbiter

Overview:
Parametrised N-source SPI input selector with priority arbitration. It forwards exactly one of NUM_SRC SPI masters (CS/SCK/MOSI) to a single downstream SPI slave port. A source that stops requesting keeps the port for a millisecond hold time. Switching happens only between frames, with a blanking gap, so the downstream slave never sees a truncated frame or a CS glitch.

Parameters:
NUM_SRC, 4, number of SPI sources (2..8)
SEL_W, 2, width of source index; must equal clog2(NUM_SRC)
DEFAULT_SRC, 0, source selected when no request is active
HOLD_MS, 16'd100, ms the current source is kept after its REQ drops
GAP_CYC, 8, CLK cycles of forced idle bus between two sources
CPOL, 0, idle level driven on CLK_OUT during blanking/reset

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
CLK_1kHz  in  1  1 kHz square wave; rising edge detected internally as the ms tick
REQ  in  NUM_SRC  per-source request, level; bit i = source i
CS_IN  in  NUM_SRC  per-source chip select, active-low
SCK_IN  in  NUM_SRC  per-source SPI clock
MOSI_IN  in  NUM_SRC  per-source data
CS_OUT  out  1  muxed chip select, registered
CLK_OUT  out  1  muxed SPI clock, registered
MOSI_OUT  out  1  muxed data, registered
ACT_SRC  out  SEL_W  index of source currently connected
BLANK  out  1  high while bus forced idle (switch gap)
SWITCH_P  out  1  one-cycle pulse when ACT_SRC changes

Behaviour:
- Reset (RST=1 at posedge CLK) values:
  - ACT_SRC=DEFAULT_SRC, state=CONNECT, hold counter=0, gap counter=0.
  - CS_OUT=1, CLK_OUT=CPOL, MOSI_OUT=0, BLANK=0, SWITCH_P=0.
  - 1 kHz edge-detect registers cleared.
- ms tick: CLK_1kHz registered twice; tick = q1 & ~q2, one CLK wide.
- Winner: lowest index i with REQ[i]=1. If no REQ bit is set, winner=DEFAULT_SRC.
- Hold counter (16 bit):
  - Cleared while REQ[ACT_SRC]=1.
  - Otherwise increments on each tick, saturating at HOLD_MS.
  - hold_exp = (counter >= HOLD_MS) or REQ[ACT_SRC]=0 with HOLD_MS=0.
- Switch wanted (want) when winner != ACT_SRC and one of:
  - REQ[winner]=1 and winner index < ACT_SRC (pre-emption by higher priority), or
  - hold_exp=1.
- CONNECT state:
  - Outputs follow CS_IN/SCK_IN/MOSI_IN[ACT_SRC] with exactly 1 CLK latency.
  - If want and CS_IN[ACT_SRC]=1 (frame idle): go to BLANK. BLANK is asserted from the next cycle.
  - If want and CS_IN[ACT_SRC]=0: stay; the switch waits for CS to rise. Pre-emption never cuts a frame.
- BLANK state:
  - CS_OUT=1, CLK_OUT=CPOL, MOSI_OUT=0.
  - Gap counter counts GAP_CYC cycles.
  - On the last gap cycle: ACT_SRC <= winner re-evaluated at that cycle, SWITCH_P=1 for one cycle, state=CONNECT, hold counter cleared.
  - If the re-evaluated winner equals the old ACT_SRC: return to CONNECT without pulsing SWITCH_P.
- Simultaneous events:
  - REQ changes during BLANK do not abort the gap; only the final winner is taken.
  - A tick coinciding with the REQ rise of the current source: clear wins.
- RST mid-frame or mid-gap: immediate return to reset values on the next edge.
  - CS_OUT goes 1 even if the source CS is low.
- GAP_CYC=0 is illegal. HOLD_MS=0 means release immediately when the request drops.

Test Plan:
1. Reset release, no REQ -> ACT_SRC=0, CS_OUT tracks CS_IN[0] delayed 1 CLK; BLANK=0, SWITCH_P never pulses.
2. REQ=4'b0100 with CS_IN[0]=1 -> BLANK high for 8 CLK, CS_OUT=1/CLK_OUT=0/MOSI_OUT=0 during gap. Then ACT_SRC=2, one SWITCH_P pulse, outputs follow source 2.
3. Source 2 active mid-frame (CS_IN[2]=0), REQ[1] rises -> no change until CS_IN[2] rises. Then gap; ACT_SRC=1.
4. Source 1 active, REQ drops to 0, HOLD_MS=100 -> ACT_SRC stays 1 for 100 ticks, then gap, then ACT_SRC=0.
5. REQ[1] re-asserted at tick 50 of the hold -> counter clears, no switch after 100 further ticks while REQ[1]=1.
6. RST pulsed during BLANK and during an active frame -> next cycle CS_OUT=1, ACT_SRC=0, BLANK=0, gap counter cleared.
